// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the ROM download writer and NUM_PORTS
// round-robin read requesters, with a single transaction in flight.
module sdram_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ioctl_download,
    input  logic                            wr_req,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            wr_ack,
    input  logic [NUM_PORTS-1:0]            rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]            rd_ack,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_q,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_owner_wr;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_rr_ptr;

    logic                   w_found;
    logic [IDX_W-1:0]       w_grant_idx;
    logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_PORTS];
    logic                   w_in_req;
    logic                   w_in_wait;

    // Unpack the per-port read addresses.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_addr_arr[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Round-robin scan from rr_ptr+1; scanning downward lets the nearest request win.
    always_comb begin
        logic [IDX_W-1:0] w_scan;
        w_found     = 1'b0;
        w_grant_idx = r_rr_ptr;
        w_scan      = r_rr_ptr;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_scan      = IDX_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
            w_found     = w_found | rd_req[w_scan];
            w_grant_idx = rd_req[w_scan] ? w_scan : w_grant_idx;
        end
    end

    assign w_in_req  = (r_state == S_REQ);
    assign w_in_wait = (r_state == S_WAIT);
    assign rd_q      = sdram_q;

    // Controller responses reach only the current owner, and only in the matching state.
    always_comb begin
        wr_ack   = sdram_ack & w_in_req & r_owner_wr;
        rd_ack   = '0;
        rd_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_ack[i]   = sdram_ack   & w_in_req  & ~r_owner_wr & (r_owner == IDX_W'(i));
            rd_valid[i] = sdram_valid & w_in_wait & ~r_owner_wr & (r_owner == IDX_W'(i));
        end
    end

    // Transaction FSM; a grant is committed until ack (write) or valid (read).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner_wr <= 1'b0;
            r_owner    <= '0;
            r_rr_ptr   <= LAST_IDX;
            sdram_req  <= 1'b0;
            sdram_we   <= 1'b0;
            sdram_addr <= '0;
            sdram_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ioctl_download) begin
                        if (wr_req) begin
                            sdram_addr <= wr_addr;
                            sdram_data <= wr_data;
                            sdram_we   <= 1'b1;
                            sdram_req  <= 1'b1;
                            r_owner_wr <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end else if (w_found) begin
                        sdram_addr <= w_addr_arr[w_grant_idx];
                        sdram_we   <= 1'b0;
                        sdram_req  <= 1'b1;
                        r_owner_wr <= 1'b0;
                        r_owner    <= w_grant_idx;
                        r_rr_ptr   <= w_grant_idx;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        r_state   <= r_owner_wr ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sdram_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    sdram_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; the bench plays the controller.
module tb_sdram_arbiter;

    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 32;

    logic              clk;
    logic              reset;
    logic              ioctl_download;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_ack;
    logic [NP-1:0]     rd_req;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP-1:0]     rd_ack;
    logic [NP-1:0]     rd_valid;
    logic [DW-1:0]     rd_q;
    logic [AW-1:0]     sdram_addr;
    logic [DW-1:0]     sdram_data;
    logic              sdram_we;
    logic              sdram_req;
    logic              sdram_ack;
    logic              sdram_valid;
    logic [DW-1:0]     sdram_q;

    int n_tests = 0;
    int n_fail  = 0;
    int c_wr_ack = 0;
    int c_rd_ack [NP];
    int c_rd_valid [NP];

    sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .rd_q(rd_q), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
        .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_valid(sdram_valid), .sdram_q(sdram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_ack) c_wr_ack++;
        for (int i = 0; i < NP; i++) begin
            if (rd_ack[i])   c_rd_ack[i]++;
            if (rd_valid[i]) c_rd_valid[i]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        c_wr_ack = 0;
        for (int i = 0; i < NP; i++) begin
            c_rd_ack[i]   = 0;
            c_rd_valid[i] = 0;
        end
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    initial begin
        int p;
        reset = 1'b1; ioctl_download = 1'b0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_req = '0; rd_addr = '0;
        sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;
        clear_counts();
        for (int i = 0; i < NP; i++) set_addr(i, AW'(23'h100 + i));

        // Reset state
        #2;
        check("rst_req", sdram_req, 0);
        check("rst_we", sdram_we, 0);
        check("rst_addr", sdram_addr, 0);
        check("rst_data", sdram_data, 0);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ack", wr_ack, 0);
        step(); step();
        reset = 1'b0;

        // Single read from port 2
        set_addr(2, 23'h001234);
        rd_req = 4'b0100;
        check("t1_idle_req", sdram_req, 0);
        step();
        check("t1_req", sdram_req, 1);
        check("t1_addr", sdram_addr, 23'h001234);
        check("t1_we", sdram_we, 0);
        step();
        check("t1_req_hold", sdram_req, 1);
        step();
        check("t1_req_hold2", sdram_req, 1);
        sdram_ack = 1'b1; #1;
        check("t1_rd_ack", rd_ack, 4'b0100);
        check("t1_wr_ack", wr_ack, 0);
        step();
        sdram_ack = 1'b0; rd_req = 4'b0000;
        check("t1_req_drop", sdram_req, 0);
        step();
        sdram_valid = 1'b1; sdram_q = 32'hCAFEF00D; #1;
        check("t1_rd_valid", rd_valid, 4'b0100);
        check("t1_rd_q", rd_q, 32'hCAFEF00D);
        step();
        sdram_valid = 1'b0;
        for (int i = 0; i < NP; i++) begin
            check($sformatf("t1_ack_cnt%0d", i), c_rd_ack[i], (i == 2) ? 1 : 0);
            check($sformatf("t1_val_cnt%0d", i), c_rd_valid[i], (i == 2) ? 1 : 0);
        end

        // Round-robin from a fresh reset
        reset = 1'b1; step(); reset = 1'b0;
        set_addr(2, 23'h000102);
        rd_req = 4'b1111;
        clear_counts();
        for (int t = 0; t < 8; t++) begin
            p = t % NP;
            check("rr_idle", sdram_req, 0);
            step();
            check($sformatf("rr_req_%0d", t), sdram_req, 1);
            check($sformatf("rr_addr_%0d", t), sdram_addr, 23'h100 + p);
            check("rr_we", sdram_we, 0);
            sdram_ack = 1'b1; #1;
            check($sformatf("rr_ack_%0d", t), rd_ack, 4'b0001 << p);
            step();
            sdram_ack = 1'b0;
            check("rr_req_drop", sdram_req, 0);
            sdram_valid = 1'b1; sdram_q = 32'h1000 + t; #1;
            check($sformatf("rr_valid_%0d", t), rd_valid, 4'b0001 << p);
            check("rr_q", rd_q, 32'h1000 + t);
            step();
            sdram_valid = 1'b0;
        end
        for (int i = 0; i < NP; i++) check($sformatf("rr_cnt%0d", i), c_rd_ack[i], 2);

        // Download write; reads ignored
        clear_counts();
        ioctl_download = 1'b1; wr_req = 1'b1;
        wr_addr = 23'h000010; wr_data = 32'hDEADBEEF; rd_req = 4'b0001;
        step();
        check("dl_req", sdram_req, 1);
        check("dl_we", sdram_we, 1);
        check("dl_addr", sdram_addr, 23'h000010);
        check("dl_data", sdram_data, 32'hDEADBEEF);
        step();
        check("dl_req_hold", sdram_req, 1);
        sdram_ack = 1'b1; #1;
        check("dl_wr_ack", wr_ack, 1);
        check("dl_rd_ack", rd_ack, 0);
        step();
        sdram_ack = 1'b0; wr_req = 1'b0;
        check("dl_req_drop", sdram_req, 0);
        step(); step(); step();
        check("dl_no_read_grant", sdram_req, 0);
        check("dl_wr_cnt", c_wr_ack, 1);
        check("dl_rd_cnt", c_rd_ack[0] + c_rd_ack[1] + c_rd_ack[2] + c_rd_ack[3], 0);

        // Download rises while port 1's read is in WAIT
        ioctl_download = 1'b0; rd_req = 4'b0010;
        clear_counts();
        step();
        check("tg_req", sdram_req, 1);
        check("tg_addr", sdram_addr, 23'h000101);
        check("tg_we", sdram_we, 0);
        sdram_ack = 1'b1; #1;
        check("tg_rd_ack", rd_ack, 4'b0010);
        step();
        sdram_ack = 1'b0; rd_req = 4'b0000;
        ioctl_download = 1'b1; wr_req = 1'b1;
        wr_addr = 23'h000020; wr_data = 32'h55AA55AA;
        check("tg_wait_req", sdram_req, 0);
        step();
        check("tg_wait_req2", sdram_req, 0);
        sdram_valid = 1'b1; sdram_q = 32'h0BADF00D; #1;
        check("tg_rd_valid", rd_valid, 4'b0010);
        check("tg_rd_q", rd_q, 32'h0BADF00D);
        step();
        sdram_valid = 1'b0;
        check("tg_idle_req", sdram_req, 0);
        step();
        check("tg_wr_req", sdram_req, 1);
        check("tg_wr_we", sdram_we, 1);
        check("tg_wr_addr", sdram_addr, 23'h000020);
        check("tg_wr_data", sdram_data, 32'h55AA55AA);
        sdram_ack = 1'b1; #1;
        check("tg_wr_ack", wr_ack, 1);
        step();
        sdram_ack = 1'b0; wr_req = 1'b0; ioctl_download = 1'b0;

        // Port 3 withdraws after grant, before ack
        clear_counts();
        rd_req = 4'b1000;
        step();
        check("wd_req", sdram_req, 1);
        check("wd_addr", sdram_addr, 23'h000103);
        rd_req = 4'b0000;
        step();
        check("wd_req_hold", sdram_req, 1);
        sdram_ack = 1'b1; #1;
        check("wd_rd_ack", rd_ack, 4'b1000);
        step();
        sdram_ack = 1'b0;
        sdram_valid = 1'b1; sdram_q = 32'h12345678; #1;
        check("wd_rd_valid", rd_valid, 4'b1000);
        step();
        sdram_valid = 1'b0;
        step();
        check("wd_idle", sdram_req, 0);
        check("wd_ack_cnt", c_rd_ack[3], 1);
        check("wd_val_cnt", c_rd_valid[3], 1);

        // Asynchronous reset while in WAIT
        rd_req = 4'b0001;
        step();
        check("ar_req", sdram_req, 1);
        check("ar_addr", sdram_addr, 23'h000100);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0; rd_req = 4'b0000;
        #2;
        reset = 1'b1;
        #1;
        check("ar_req_async", sdram_req, 0);
        check("ar_addr_async", sdram_addr, 0);
        step();
        reset = 1'b0;
        clear_counts();
        sdram_valid = 1'b1; sdram_q = 32'h00000001; #1;
        check("ar_stray_valid", rd_valid, 0);
        sdram_ack = 1'b1; #1;
        check("ar_stray_ack", rd_ack, 0);
        check("ar_stray_wr_ack", wr_ack, 0);
        step();
        sdram_valid = 1'b0; sdram_ack = 1'b0;
        check("ar_val_cnt", c_rd_valid[0] + c_rd_valid[1] + c_rd_valid[2] + c_rd_valid[3], 0);
        check("ar_idle_req", sdram_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port between the ROM download writer and up to NUM_PORTS read requesters (CPU program ROM, sound ROM, tile/sprite ROMs). It sits between the game's ROM fetch logic and the `sdram` controller. It allows one transaction in flight and serves the download port exclusively while `ioctl_download` is high. Read requesters are served round-robin.

## Interface
Parameters:
- NUM_PORTS, 4, number of read requesters (1..8)
- ADDR_WIDTH, 23, SDRAM word address width
- DATA_WIDTH, 32, SDRAM data width

Ports:
- clk  in  1  system clock (48 MHz)
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  ROM download active; only the write port is served
- wr_req  in  1  write request, held until wr_ack
- wr_addr  in  ADDR_WIDTH  write address, stable while wr_req
- wr_data  in  DATA_WIDTH  write data, stable while wr_req
- wr_ack  out  1  one-cycle pulse: write accepted by the controller
- rd_req  in  NUM_PORTS  per-port read request, held until rd_ack
- rd_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, packed with port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_ack  out  NUM_PORTS  one-cycle pulse: port's read accepted
- rd_valid  out  NUM_PORTS  one-cycle pulse: rd_q holds the port's data
- rd_q  out  DATA_WIDTH  shared read data
- sdram_addr  out  ADDR_WIDTH; sdram_data  out  DATA_WIDTH; sdram_we  out  1; sdram_req  out  1  controller request side
- sdram_ack  in  1; sdram_valid  in  1; sdram_q  in  DATA_WIDTH  controller response side

## Operation
- State machine with three states: IDLE, REQ, WAIT. Registers: state, owner (write or read index), rr_ptr (last-granted read index).
- In IDLE, with ioctl_download=1: if wr_req=1, latch wr_addr/wr_data, set sdram_we=1 and owner=write, then go to REQ. rd_req is ignored.
- In IDLE, with ioctl_download=0: choose the first asserted rd_req searching from rr_ptr+1 upward, wrapping modulo NUM_PORTS. Latch its address, set sdram_we=0, owner=i, rr_ptr=i, then go to REQ. wr_req is ignored.
- REQ: hold sdram_req=1 and the latched addr/data/we. On sdram_ack, drop sdram_req. A write returns to IDLE. A read goes to WAIT.
- WAIT: on sdram_valid, return to IDLE.
- Response routing is combinational and gated by owner/state:
  - wr_ack = sdram_ack & REQ & owner==write
  - rd_ack[i] = sdram_ack & REQ & owner==i
  - rd_valid[i] = sdram_valid & WAIT & owner==i
  - rd_q = sdram_q always
- Responses outside those states or for other owners are dropped, with no pulse on any port.
- A granted transaction is committed. If the requester drops req before ack, the transaction still completes and is still acked and validated to that port.
- ioctl_download changing mid-transaction does not abort it. The new mode applies from the next IDLE.
- Reset values: state=IDLE, sdram_req=0, sdram_we=0, sdram_addr=0, sdram_data=0, rr_ptr=NUM_PORTS-1 (so port 0 wins first), and all ack/valid outputs 0. An asynchronous reset mid-transaction abandons it with no pulse delivered. The controller is reset independently.

## Timing
- Grant latency: a request seen in IDLE at cycle n gives sdram_req=1 and stable addr/data/we at cycle n+1.
- sdram_req stays high until the cycle sdram_ack is seen, and is 0 in the following cycle.
- Ack and valid reach the requester in the same cycle they arrive from the controller, with no added latency.
- After ack (write) or valid (read), the arbiter is in IDLE the next cycle. The earliest next sdram_req is 2 cycles after that ack/valid.
- The earliest back-to-back read throughput is therefore controller latency + 2 cycles per transaction.
- Round-robin guarantees each continuously requesting read port is granted at least once every NUM_PORTS transactions.
- All outputs are registered, except ack/valid/rd_q, which are gated combinationally.

## Test plan
- **Reset and single read:** rd_req[2]=1, addr 0x1234, with a model acking 3 cycles later and valid 5 cycles later. Expect sdram_req at n+1 with sdram_addr=0x1234 and we=0, one rd_ack[2] pulse, one rd_valid[2] pulse with rd_q = model data, and no pulses on other ports.
- **Round-robin:** hold rd_req=4'b1111 for 8 transactions. Expect grants in order 0,1,2,3,0,1,2,3.
- **Download:** ioctl_download=1, wr_req with addr 0x000010 and data 0xDEADBEEF, while rd_req=4'b0001. Expect sdram_we=1 with that addr/data and one wr_ack, and no rd_ack for the whole download.
- **Download toggle mid-read:** port 1's read in WAIT, then ioctl_download rises. Expect rd_valid[1] still delivered, followed by the pending write granted next.
- **Requester withdrawal:** rd_req[3] dropped after grant but before ack. Expect rd_ack[3] and rd_valid[3] still pulse once each, and the arbiter returns to IDLE.
- **Async reset:** assert reset in WAIT. Expect sdram_req=0 immediately with no clock edge, and a stray sdram_valid after release produces no rd_valid.
